operand_skid_reg: RTL and testbench
===================================

Name: operand_skid_reg

Overview:
- Parametrised operand-capture stage at the front of the Booth-Wallace multiplier.
- Registers the A/B operand pair behind a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput with a registered in_ready.
- Flags zero operands so the downstream multiplier can short-circuit, and counts delivered pairs.

Parameters:
- WIDTH, 8, bit width of each operand (A and B); legal range ≥ 2.
- CNT_W, 16, width of the delivered-pair counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low.
- flush  input  1  synchronous clear of buffered pairs, active-high.
- in_valid  input  1  producer presents a valid pair.
- in_ready  output  1  stage can accept a pair this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- out_valid  output  1  a_out/b_out hold a valid pair.
- out_ready  input  1  consumer accepts the pair.
- a_out  output  WIDTH  registered operand A.
- b_out  output  WIDTH  registered operand B.
- out_zero  output  1  registered flag: a_out==0 or b_out==0.
- level  output  2  occupancy, 0..2.
- pair_count  output  CNT_W  number of completed output transfers, modulo 2^CNT_W.

Behaviour:
- Clock and reset: single clock. The reset port is synchronous and active-low. It is sampled only on the rising edge of clk and has priority over everything else.
- Reset values: out_valid=0, a_out=0, b_out=0, out_zero=0, level=0, pair_count=0, skid entry cleared. While reset is low, in_ready=0.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register. Each entry holds {a, b, zero}. zero is computed from a_in/b_in at capture time.
- States:
  - EMPTY (level 0).
  - ONE (main valid, level 1).
  - FULL (main and skid valid, level 2).
- Combinational outputs:
  - in_ready = reset high & state != FULL. It depends on state only, never on out_ready.
  - out_valid = state != EMPTY.
- Transitions:
  - EMPTY: accept -> main<=in, go to ONE.
  - ONE:
    - accept & drain -> main<=in, stay in ONE.
    - accept & !drain -> skid<=in, go to FULL.
    - !accept & drain -> EMPTY.
    - otherwise hold.
  - FULL: drain -> main<=skid, go to ONE. Otherwise hold.
- Latency and throughput: 1 cycle from accept to out_valid when passing through main. Sustained throughput is 1 pair/cycle when out_ready stays high. Pairs are delivered strictly in order, with no duplication or loss.
- Holding outputs: when EMPTY, a_out/b_out/out_zero hold their last values. The bench checks them only when out_valid=1. A stalled output (out_valid & !out_ready) holds stable until drained.
- pair_count: +1 on every drain. Wraps from 2^CNT_W-1 to 0. Not cleared by flush.
- flush (reset high):
  - Next state is EMPTY and the skid entry is cleared.
  - An accept in the same cycle is discarded.
  - A drain in the same cycle still counts, since the consumer took the data.
  - a_out/b_out hold their values.
- Reset mid-operation: all buffered pairs are dropped and everything returns to reset values. This takes priority over flush.
- Arithmetic: no arithmetic on the data path; operands pass unsigned and bit-exact. out_zero is a pure reduction-NOR of each operand, ORed together.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum {ST_EMPTY, ST_ONE, ST_FULL};
  - the default WIDTH=8;
  - the operand-pair struct {a, b, zero}, parametrised by WIDTH via localparam.
- Natural sub-module: operand_pair_reg, a WIDTH-generic load-enabled register holding one pair and its zero flag. It is instantiated twice (main, skid). Control stays in operand_skid_reg.

Test Plan:
- Reset: hold reset low 3 cycles with in_valid=1, a_in=8'h5A -> in_ready=0, out_valid=0, level=0, pair_count=0. Release -> in_ready=1 next cycle.
- Streaming: out_ready=1, send (3,7), (8'hFF,2), (0,9) on consecutive cycles -> same pairs out 1 cycle later in order. out_zero=0,0,1. pair_count=3.
- Back-pressure: out_ready=0, send (1,1) then (2,2) -> level=2, in_ready=0, outputs hold (1,1). Raise out_ready -> (1,1) then (2,2) delivered, level returns to 0, no loss.
- Simultaneous: in ONE with (4,4), assert accept of (5,5) and drain in the same cycle -> level stays 1, a_out=5, pair_count +1.
- Flush: in FULL, assert flush with in_valid=1 (6,6) -> next cycle level=0, out_valid=0, (6,6) never appears, pair_count unchanged.
- Wrap: CNT_W=2, drain 5 pairs -> pair_count sequence 1,2,3,0,1. Also run WIDTH=16 with a_in=16'h0000, b_in=16'hFFFF -> out_zero=1.

Source files
------------

// File: rtl/operand_skid_reg_pkg.sv
// mult_pkg: shared types and defaults for the multiplier operand front end.
package mult_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 zero;
  } pair_t;
endpackage

// File: rtl/operand_skid_reg_if.sv
// operand_skid_reg_if: operand pair handshake on both sides of the capture stage.
interface operand_skid_reg_if import mult_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             out_zero;
  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, a_out, b_out, out_zero
  );
  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, a_out, b_out, out_zero
  );
endinterface

// File: rtl/operand_skid_reg_pair.sv
// operand_pair_reg: load-enabled register holding one operand pair and its zero flag.
module operand_pair_reg import mult_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             zero_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             zero_o
);
  logic [WIDTH-1:0] a_q, b_q;
  logic             zero_q;
  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      a_q    <= '0;
      b_q    <= '0;
      zero_q <= 1'b0;
    end else if (ld_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      zero_q <= zero_i;
    end
  end
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign zero_o = zero_q;
endmodule

// File: rtl/operand_skid_reg.sv
// operand_skid_reg: 2-entry skid capture of A/B operands with zero flag and delivered-pair counter.
module operand_skid_reg import mult_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  operand_skid_reg_if.slave  bus,
  output logic [1:0]         level,
  output logic [CNT_W-1:0]   pair_count
);
  state_e           state_q, state_d;
  logic             accept, drain, in_zero, main_ld, skid_ld, sel_skid, skid_zero;
  logic [WIDTH-1:0] skid_a, skid_b;
  logic [CNT_W-1:0] cnt_q;
  assign bus.in_ready  = reset && state_q != ST_FULL;
  assign bus.out_valid = state_q != ST_EMPTY;
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = bus.out_valid && bus.out_ready;
  assign in_zero       = ~|bus.a_in | ~|bus.b_in;
  assign level         = state_q;
  assign pair_count    = cnt_q;
  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    sel_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        main_ld = accept;
        state_d = accept ? ST_ONE : ST_EMPTY;
      end
      ST_ONE: begin
        main_ld = accept && drain;
        skid_ld = accept && !drain;
        state_d = skid_ld ? ST_FULL : (!accept && drain) ? ST_EMPTY : ST_ONE;
      end
      ST_FULL: begin
        main_ld  = drain;
        sel_skid = 1'b1;
        state_d  = drain ? ST_ONE : ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush drops buffered pairs but leaves the main outputs frozen
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= !reset ? ST_EMPTY : state_d;
    if (!reset) cnt_q <= '0;
    else if (drain) cnt_q <= cnt_q + CNT_W'(1);
  end
  operand_pair_reg #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (1'b0),
    .ld_i   (main_ld),
    .a_i    (sel_skid ? skid_a : bus.a_in),
    .b_i    (sel_skid ? skid_b : bus.b_in),
    .zero_i (sel_skid ? skid_zero : in_zero),
    .a_o    (bus.a_out),
    .b_o    (bus.b_out),
    .zero_o (bus.out_zero)
  );
  operand_pair_reg #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (flush),
    .ld_i   (skid_ld),
    .a_i    (bus.a_in),
    .b_i    (bus.b_in),
    .zero_i (in_zero),
    .a_o    (skid_a),
    .b_o    (skid_b),
    .zero_o (skid_zero)
  );
endmodule

// File: tb/tb_operand_skid_reg.sv
// tb_operand_skid_reg: scoreboard bench for operand_skid_reg at 8-bit and 16-bit/2-bit-counter sizes.
module tb_operand_skid_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  lvl1, lvl2;
  logic [15:0] cnt1_o;
  logic [1:0]  cnt2_o;
  logic [32:0] q1[$], q2[$];
  int          n_chk = 0, n_pass = 0;
  int          cnt1 = 0, cnt2 = 0;
  operand_skid_reg_if #(.WIDTH(8))  b1();
  operand_skid_reg_if #(.WIDTH(16)) b2();
  operand_skid_reg #(.WIDTH(8), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b1.slave), .level(lvl1), .pair_count(cnt1_o)
  );
  operand_skid_reg #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b2.slave), .level(lvl2), .pair_count(cnt2_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (reset) begin
      chk("d1_cnt", 64'(cnt1_o), 64'(cnt1 % 65536));
      chk("d2_cnt", 64'(cnt2_o), 64'(cnt2 % 4));
    end
    if (reset && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) chk("d1_unexpected_out", 64'(1), 64'(0));
      else chk("d1_pair", 64'({b1.a_out, b1.b_out, b1.out_zero}), 64'(q1.pop_front()));
      cnt1++;
    end
    if (reset && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) chk("d2_unexpected_out", 64'(1), 64'(0));
      else chk("d2_pair", 64'({b2.a_out, b2.b_out, b2.out_zero}), 64'(q2.pop_front()));
      cnt2++;
    end
    if (!reset || flush) begin
      q1.delete();
      q2.delete();
      if (!reset) begin
        cnt1 = 0;
        cnt2 = 0;
      end
    end else begin
      if (b1.in_valid && b1.in_ready)
        q1.push_back(33'({b1.a_in, b1.b_in, b1.a_in == 8'd0 || b1.b_in == 8'd0}));
      if (b2.in_valid && b2.in_ready)
        q2.push_back(33'({b2.a_in, b2.b_in, b2.a_in == 16'd0 || b2.b_in == 16'd0}));
    end
  end
  task automatic send1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    b1.in_valid = v;
    b1.a_in = a;
    b1.b_in = b;
    b1.out_ready = rdy;
    step();
  endtask
  initial begin
    b1.in_valid = 1'b1; b1.a_in = 8'h5A; b1.b_in = 8'h5A; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.a_in = '0; b2.b_in = '0; b2.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 64'(b1.in_ready), 64'(0));
    chk("rst_out_valid", 64'(b1.out_valid), 64'(0));
    chk("rst_level", 64'(lvl1), 64'(0));
    chk("rst_count", 64'(cnt1_o), 64'(0));
    chk("rst_zero", 64'(b1.out_zero), 64'(0));
    chk("rst_a_out", 64'(b1.a_out), 64'(0));
    reset = 1'b1;
    b1.in_valid = 1'b0;
    step();
    chk("rel_in_ready", 64'(b1.in_ready), 64'(1));
    send1(1, 8'd3, 8'd7, 1);
    chk("str_a0", 64'({b1.out_valid, b1.a_out, b1.b_out, b1.out_zero}), 64'({1'b1, 8'd3, 8'd7, 1'b0}));
    send1(1, 8'hFF, 8'd2, 1);
    chk("str_a1", 64'({b1.out_valid, b1.a_out, b1.b_out, b1.out_zero}), 64'({1'b1, 8'hFF, 8'd2, 1'b0}));
    send1(1, 8'd0, 8'd9, 1);
    chk("str_a2", 64'({b1.out_valid, b1.a_out, b1.b_out, b1.out_zero}), 64'({1'b1, 8'd0, 8'd9, 1'b1}));
    send1(0, 8'd0, 8'd0, 1);
    chk("str_level", 64'(lvl1), 64'(0));
    chk("str_count", 64'(cnt1_o), 64'(3));
    send1(1, 8'd1, 8'd1, 0);
    chk("bp_level1", 64'(lvl1), 64'(1));
    send1(1, 8'd2, 8'd2, 0);
    chk("bp_full", 64'({lvl1, b1.in_ready}), 64'({2'd2, 1'b0}));
    chk("bp_hold", 64'({b1.a_out, b1.b_out}), 64'({8'd1, 8'd1}));
    send1(0, 8'd0, 8'd0, 0);
    chk("bp_stall", 64'({b1.out_valid, b1.a_out}), 64'({1'b1, 8'd1}));
    send1(0, 8'd0, 8'd0, 1);
    chk("bp_drain1", 64'({lvl1, b1.a_out, b1.b_out}), 64'({2'd1, 8'd2, 8'd2}));
    send1(0, 8'd0, 8'd0, 1);
    chk("bp_empty", 64'({lvl1, b1.out_valid}), 64'({2'd0, 1'b0}));
    chk("bp_count", 64'(cnt1_o), 64'(5));
    send1(1, 8'd4, 8'd4, 0);
    chk("sim_one", 64'({lvl1, b1.a_out}), 64'({2'd1, 8'd4}));
    send1(1, 8'd5, 8'd5, 1);
    chk("sim_pass", 64'({lvl1, b1.a_out}), 64'({2'd1, 8'd5}));
    chk("sim_count", 64'(cnt1_o), 64'(6));
    send1(1, 8'd7, 8'd7, 0);
    chk("fl_full", 64'(lvl1), 64'(2));
    flush = 1'b1;
    send1(1, 8'd6, 8'd6, 0);
    flush = 1'b0;
    chk("fl_empty", 64'({lvl1, b1.out_valid}), 64'({2'd0, 1'b0}));
    chk("fl_count", 64'(cnt1_o), 64'(6));
    repeat (3) send1(0, 8'd0, 8'd0, 1);
    for (int i = 0; i < 80; i++) begin
      send1(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    repeat (3) send1(0, 8'd0, 8'd0, 1);
    chk("q1_empty", 64'(q1.size()), 64'(0));
    send1(1, 8'd9, 8'd9, 0);
    send1(1, 8'd10, 8'd10, 0);
    chk("mr_full", 64'(lvl1), 64'(2));
    b1.in_valid = 1'b0;
    reset = 1'b0;
    step();
    chk("mr_state", 64'({lvl1, b1.out_valid, b1.in_ready}), 64'({2'd0, 1'b0, 1'b0}));
    chk("mr_count", 64'(cnt1_o), 64'(0));
    reset = 1'b1;
    step();
    b2.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b2.in_valid = 1'b1;
      b2.a_in = (i == 0) ? 16'h0000 : 16'(i * 16'h1111);
      b2.b_in = (i == 0) ? 16'hFFFF : 16'(16'hF00D - i);
      step();
      if (i == 0) chk("w16_zero", 64'({b2.out_valid, b2.out_zero}), 64'({1'b1, 1'b1}));
      else chk("wrap_count", 64'(cnt2_o), 64'(i % 4));
    end
    b2.in_valid = 1'b0;
    step();
    chk("wrap_last", 64'(cnt2_o), 64'(1));
    step();
    chk("q2_empty", 64'(q2.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
